serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around the existing full_adder cell.
//   - Adds one bit per clock, LSB first.
//   - Keeps the carry in a flip-flop between bits.
//   - Upstream control issues operands with a start pulse.
//   - The result is held with a done strobe for the downstream consumer.
//   - Trades latency for area versus a ripple-carry array of full_adder cells.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (legal range 2..32)
// PORTS
//   clk    input   1      rising-edge clock
//   rst    input   1      asynchronous, active-high reset
//   start  input   1      request; sampled only in IDLE
//   a      input   WIDTH  operand A; captured on the accepted start edge
//   b      input   WIDTH  operand B; captured on the accepted start edge
//   cin    input   1      carry-in; captured on the accepted start edge
//   busy   output  1      high while in RUN
//   done   output  1      one-cycle strobe; high while in DONE
//   sum    output  WIDTH  result; held until the next accepted start
//   cout   output  1      carry-out; held until the next accepted start
// BEHAVIOUR
//   Ports: one clock and one reset. Reset is asynchronous and active-high.
//   Reset (any time, including mid-RUN):
//     - state=IDLE.
//     - busy=0, done=0, sum=0, cout=0.
//     - Shift registers, carry flop and bit counter all cleared.
//     - Any in-flight addition is discarded. No done is produced for it.
//   Datapath:
//     - One full_adder instance, port order (s, cout, a, b, cin).
//     - Inputs: LSB of A shift register, LSB of B shift register, carry flop.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - If start=1 at an edge: load a, b into the shift registers and cin into
//       the carry flop; counter=0; go to RUN.
//     - Else remain in IDLE.
//   RUN, on each edge:
//     - The full_adder s output shifts into the sum register at the MSB.
//       The sum register shifts right.
//     - The A and B shift registers shift right.
//     - The carry flop takes the full_adder cout output.
//     - The counter increments.
//     - On the edge where counter==WIDTH-1, go to DONE. At that edge sum holds
//       all WIDTH bits and cout takes the final carry.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   Latency:
//     - start is accepted at edge E0.
//     - done is high in the cycle between edge E0+WIDTH and edge E0+WIDTH+1.
//     - Minimum issue interval is WIDTH+2 cycles.
//   start handling:
//     - Ignored in RUN and DONE. It is not queued.
//     - A start held high through DONE is accepted at the first IDLE edge.
//   Operand stability: a, b and cin may change freely after the accepted edge
//     without affecting the result.
//   Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Exact; no
//     overflow flag.
//   Visibility: sum/cout update bit by bit during RUN. They are valid only
//     from done=1 until the next accepted start.
// TESTING (WIDTH=8)
//   1. a=00, b=00, cin=0, pulse start -> done 8 edges later; sum=00, cout=0;
//      busy high for 8 cycles.
//   2. a=FF, b=01, cin=0 -> sum=00, cout=1.
//      a=FF, b=FF, cin=1 -> sum=FF, cout=1.
//      a=A5, b=5A, cin=0 -> sum=FF, cout=0.
//   3. Accept a=0F, b=01; pulse start with a=FF, b=FF during RUN and again in
//      DONE -> second request ignored; sum=10, cout=0; exactly one done pulse.
//   4. Accept a=80, b=80; assert rst at RUN cycle 4 -> busy=0, done=0, sum=00,
//      cout=0 immediately with no clock edge; no done ever follows.
//   5. Hold start high continuously: a=01, b=02 then a=03, b=04 -> results 03
//      then 07; done pulses 10 cycles apart.
//   6. Random: 200 random a, b, cin -> {cout,sum} == a+b+cin each time; sum
//      stays stable from done until the next accepted start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell, LSB first, carry held in a flop between bits.
// A start in IDLE captures the operands; done pulses once the last bit has been summed.

module full_adder (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start; result from the previous add is held
// RUN   | one bit summed per edge, LSB first
// DONE  | result complete; done high for this single cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_cout;

  full_adder u_fa (
    .s    (fa_s),
    .cout (fa_cout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // The carry flop doubles as the carry-out register once the last bit is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector and corner-sequence bench for serial_adder at WIDTH=8.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (at negedges) for done; ok=0 if it never arrives within the budget.
  task automatic wait_done(output bit ok, output int lat, output int busy_cycles);
    ok = 0; lat = 0; busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin ok = 1; break; end
      if (busy) busy_cycles++;
      lat++;
      @(negedge clk);
    end
  endtask

  // Issues one add, scrambles operands after acceptance, and returns the result.
  task automatic do_add(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        output logic [7:0] s, output logic c, output bit ok,
                        output int lat, output int bc);
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done(ok, lat, bc);
    s = sum; c = cout;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] s, s_hold;
    logic       c;
    logic [8:0] exp9;
    bit         ok;
    int         lat, bc, d0, t1, t2;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};

    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, ok, lat, bc);
      check("vec_done_seen", {31'd0, ok}, 32'd1);
      check("vec_latency", lat, 32'd8);
      check("vec_busy_cycles", bc, 32'd8);
      check("vec_sum", {24'd0, s}, {24'd0, vecs[i].sum});
      check("vec_cout", {31'd0, c}, {31'd0, vecs[i].cout});
    end

    // Starts during RUN and during DONE must be ignored.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (done) ok = 1;
      else @(negedge clk);
    end
    check("ign_done_seen", {31'd0, ok}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_idle_busy", {31'd0, busy}, 32'd0);
    repeat (14) @(negedge clk);
    check("ign_done_pulses", done_cnt - d0, 32'd1);
    check("ign_sum", {24'd0, sum}, 32'h10);
    check("ign_cout", {31'd0, cout}, 32'd0);

    // Mid-RUN asynchronous reset discards the add.
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 32'd0);

    // start held high: back-to-back adds one issue interval apart.
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    wait_done(ok, lat, bc);
    t1 = cyc;
    check("hold_done1", {31'd0, ok}, 32'd1);
    check("hold_sum1", {24'd0, sum}, 32'h03);
    @(negedge clk);
    wait_done(ok, lat, bc);
    t2 = cyc;
    start = 1'b0;
    check("hold_done2", {31'd0, ok}, 32'd1);
    check("hold_sum2", {24'd0, sum}, 32'h07);
    check("hold_interval", t2 - t1, 32'd10);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      do_add(ra, rb, rc, s, c, ok, lat, bc);
      check("rnd_done_seen", {31'd0, ok}, 32'd1);
      check("rnd_result", {23'd0, c, s}, {23'd0, exp9});
      s_hold = s;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("rnd_hold", {23'd0, cout, sum}, {23'd0, exp9[8], s_hold});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
